// File: rtl/boot_loader_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_pkg
//  Description : Shared types and constants for the UART boot sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

    // Boot sequencer states; the encoding is exported on boot_state.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        REQ_P  = 4'd1,
        LEN_P  = 4'd2,
        BODY_P = 4'd3,
        REQ_D  = 4'd4,
        LEN_D  = 4'd5,
        BODY_D = 4'd6,
        RUN    = 4'd7,
        ERR    = 4'd8
    } boot_state_t;

    localparam logic [7:0] BOOT_ERR_BYTE = 8'hEE;
    localparam logic [7:0] REQ_PROG_DEF  = 8'h99;
    localparam logic [7:0] REQ_DATA_DEF  = 8'hAA;

    // True in the states where host bytes belong to an image.
    function automatic logic state_accepts_bytes(input boot_state_t s);
        return (s == LEN_P) || (s == BODY_P) || (s == LEN_D) || (s == BODY_D);
    endfunction

endpackage
`default_nettype wire

// File: rtl/boot_loader_ctrl_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Packs UART bytes into 32-bit little-endian words and emits a
//                one-cycle word_valid the cycle after the fourth byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q,   idx_d;
    logic [31:0] word_q,  word_d;
    logic        valid_q, valid_d;

    // Drop each byte into its lane; the word is complete on lane 3.
    always_comb begin
        idx_d   = idx_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear) begin
            idx_d = 2'd0;
        end else if (byte_valid) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_data;
            idx_d   = idx_q + 2'd1;
            valid_d = (idx_q == 2'd3);
        end
    end

    // State registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q   <= 2'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word       = word_q;

endmodule
`default_nettype wire

// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader_ctrl
//  Description : Requests program and data images over UART, writes them into
//                instruction/data memory and then releases the core.
//                Optional feature macro: BOOT_CHECKSUM_EN (XOR checksum byte
//                after each image, ERR state on mismatch).
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter int         IADDR_W  = 10,
    parameter int         DADDR_W  = 10,
    parameter logic [7:0] REQ_PROG = REQ_PROG_DEF,
    parameter logic [7:0] REQ_DATA = REQ_DATA_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               tx_busy,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    output logic               core_rstn,
    output logic [3:0]         boot_state
);

    boot_state_t        state_q, state_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [IADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]        len_q, len_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               core_rstn_q, core_rstn_d;

    logic               w_in_image;
    logic               w_byte_take;
    logic               w_word_valid;
    logic [31:0]        w_word;
    logic               w_phase_done;
    boot_state_t        w_next_phase;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0]         xor_q, xor_d;
    logic               chk_wait_q, chk_wait_d;
    logic               err_sent_q, err_sent_d;
    logic               w_chk_slot;

    // Once the image body is complete the next byte is the checksum, not data.
    assign w_chk_slot  = chk_wait_q | w_phase_done;
    assign w_byte_take = rx_valid & w_in_image & ~w_chk_slot;
`else
    assign w_byte_take = rx_valid & w_in_image;
`endif

    assign w_in_image = state_accepts_bytes(state_q);

    // Assembler is held clear outside image states, so every phase starts at lane 0.
    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (!w_in_image),
        .byte_valid (w_byte_take),
        .byte_data  (rx_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    // Detect the end of an image: zero length, or the N-th word being written.
    always_comb begin
        w_phase_done = 1'b0;
        w_next_phase = ((state_q == LEN_P) || (state_q == BODY_P)) ? REQ_D : RUN;
        case (state_q)
            LEN_P, LEN_D:   w_phase_done = w_word_valid && (w_word == 32'd0);
            BODY_P, BODY_D: w_phase_done = w_word_valid && ((cnt_q + 32'd1) == len_q);
            default:        w_phase_done = 1'b0;
        endcase
    end

    // Sequencer next-state and output computation.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        imem_addr_d = imem_addr_q;
        dmem_addr_d = dmem_addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        tx_start    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        xor_d       = xor_q;
        chk_wait_d  = chk_wait_q;
        err_sent_d  = err_sent_q;
`endif
        case (state_q)
            IDLE: begin
                state_d   = REQ_P;
                tx_data_d = REQ_PROG;
            end
            REQ_P, REQ_D: begin
                // Strobe decoded from state so it coincides with the tx_busy==0 sample.
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = (state_q == REQ_P) ? LEN_P : LEN_D;
                end
            end
            LEN_P, LEN_D: begin
                if (w_word_valid) begin
                    len_d = w_word;
                    cnt_d = 32'd0;
                    if (w_word != 32'd0) begin
                        state_d = (state_q == LEN_P) ? BODY_P : BODY_D;
                    end
                end
            end
            BODY_P: begin
                if (w_word_valid) begin
                    imem_addr_d = imem_addr_q + IADDR_W'(1);
                    cnt_d       = cnt_q + 32'd1;
                end
            end
            BODY_D: begin
                if (w_word_valid) begin
                    dmem_addr_d = dmem_addr_q + DADDR_W'(1);
                    cnt_d       = cnt_q + 32'd1;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ERR: begin
                if (!tx_busy && !err_sent_q) begin
                    tx_start   = 1'b1;
                    err_sent_d = 1'b1;
                end
            end
`endif
            default: state_d = state_q;
        endcase

`ifdef BOOT_CHECKSUM_EN
        if (!w_in_image) begin
            xor_d = 8'd0;
        end else if (w_byte_take) begin
            xor_d = xor_q ^ rx_data;
        end
        if (w_chk_slot && rx_valid) begin
            chk_wait_d = 1'b0;
            if (rx_data == xor_q) begin
                state_d = w_next_phase;
            end else begin
                state_d   = ERR;
                tx_data_d = BOOT_ERR_BYTE;
            end
        end else if (w_phase_done) begin
            chk_wait_d = 1'b1;
        end
`else
        if (w_phase_done) begin
            state_d = w_next_phase;
        end
`endif

        if ((state_d == REQ_D) && (state_q != REQ_D)) begin
            tx_data_d = REQ_DATA;
        end
        core_rstn_d = (state_d == RUN);
    end

    // All sequencer registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            tx_data_q   <= 8'd0;
            imem_addr_q <= '0;
            dmem_addr_q <= '0;
            len_q       <= 32'd0;
            cnt_q       <= 32'd0;
            core_rstn_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            xor_q       <= 8'd0;
            chk_wait_q  <= 1'b0;
            err_sent_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            imem_addr_q <= imem_addr_d;
            dmem_addr_q <= dmem_addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            core_rstn_q <= core_rstn_d;
`ifdef BOOT_CHECKSUM_EN
            xor_q       <= xor_d;
            chk_wait_q  <= chk_wait_d;
            err_sent_q  <= err_sent_d;
`endif
        end
    end

    assign tx_data    = tx_data_q;
    assign imem_we    = w_word_valid && (state_q == BODY_P);
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = w_word;
    assign dmem_we    = w_word_valid && (state_q == BODY_D);
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = w_word;
    assign core_rstn  = core_rstn_q;
    assign boot_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boot_loader_ctrl
//  Description : Scoreboard bench for boot_loader_ctrl with randomized images.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader_ctrl;

    localparam int IADDR_W = 10;
    localparam int DADDR_W = 10;
    localparam int K_TX    = 0;
    localparam int K_IMEM  = 1;
    localparam int K_DMEM  = 2;
    localparam int K_RUN   = 3;

    logic               clk      = 1'b0;
    logic               reset    = 1'b0;
    logic [7:0]         rx_data  = 8'd0;
    logic               rx_valid = 1'b0;
    logic               tx_busy  = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               imem_we;
    logic [IADDR_W-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic               core_rstn;
    logic [3:0]         boot_state;

    always #5 clk = ~clk;

    boot_loader_ctrl #(
        .IADDR_W (IADDR_W),
        .DADDR_W (DADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .core_rstn  (core_rstn),
        .boot_state (boot_state)
    );

    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] data;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog_q[$];
    logic [31:0] data_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          tx_count  = 0;
    int          tx_target = 0;
    int          cyc       = 0;
    int          last_dmem = -100;
    logic        prev_rstn = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic expect_push(input int kind, input int addr, input logic [31:0] data, input bit lat);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.lat  = lat;
        sb.push_back(e);
        if (kind == K_TX) tx_target++;
    endtask

    task automatic check_evt(input int kind, input int addr, input logic [31:0] data);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_event got kind=%0d addr=%0d data=%h, expected nothing", kind, addr, data);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.addr != addr || e.data !== data ||
                (kind == K_RUN && e.lat && (cyc - last_dmem) != 1)) begin
                failures++;
                $display("FAIL sb_event got kind=%0d addr=%0d data=%h dlat=%0d, expected kind=%0d addr=%0d data=%h dlat=1",
                         kind, addr, data, cyc - last_dmem, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every DUT output event is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (tx_start) begin
                    check_evt(K_TX, 0, {24'd0, tx_data});
                    tx_count++;
                end
                if (imem_we) check_evt(K_IMEM, int'(imem_addr), imem_wdata);
                if (dmem_we) begin
                    check_evt(K_DMEM, int'(dmem_addr), dmem_wdata);
                    last_dmem = cyc;
                end
                if (core_rstn && !prev_rstn) check_evt(K_RUN, 0, 32'd0);
            end
            prev_rstn = core_rstn;
        end
    end

    // UART transmitter model: busy after each strobe, plus random holdoffs.
    initial begin
        int left;
        bit seen;
        left = 0;
        forever begin
            @(negedge clk);
            seen = tx_start && reset;
            @(posedge clk);
            #1;
            if (seen) left = $urandom_range(1, 6);
            else if (left > 0) left--;
            else if ($urandom_range(0, 7) == 0) left = $urandom_range(1, 3);
            tx_busy = (left != 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gmax);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat ($urandom_range(0, gmax)) step();
    endtask

    task automatic wait_tx(input string name);
        for (int i = 0; i < 400 && tx_count < tx_target; i++) step();
        checks++;
        if (tx_count < tx_target) begin
            failures++;
            $display("FAIL %s got=%0d tx expected=%0d", name, tx_count, tx_target);
            tx_target = tx_count;
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b0;
        step();
        step();
        chk("rst_state", {28'd0, boot_state}, 32'd0);
        chk("rst_core_rstn", {31'd0, core_rstn}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_we", {30'd0, imem_we, dmem_we}, 32'd0);
        chk("rst_addr", {12'd0, imem_addr, dmem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata | dmem_wdata, 32'd0);
        chk("rst_sb_drained", sb.size(), 32'd0);
        sb.delete();
        tx_target = tx_count;
        reset = 1'b1;
        expect_push(K_TX, 0, 32'h99, 1'b0);
    endtask

    task automatic fill(input int pn, input int dn);
        prog_q.delete();
        data_q.delete();
        for (int i = 0; i < pn; i++) prog_q.push_back($urandom);
        for (int i = 0; i < dn; i++) data_q.push_back($urandom);
    endtask

    // Reference model: image i word k lands at address k mod 2^W, then the next step follows.
    task automatic send_image(input bit is_data, input int gmax, input bit bad);
        int          n;
        logic [31:0] w;
        logic [7:0]  b;
        logic [7:0]  x;
        n = is_data ? data_q.size() : prog_q.size();
        for (int i = 0; i < n; i++) begin
            w = is_data ? data_q[i] : prog_q[i];
            expect_push(is_data ? K_DMEM : K_IMEM, i % (1 << (is_data ? DADDR_W : IADDR_W)), w, 1'b0);
        end
`ifdef BOOT_CHECKSUM_EN
        if (bad) expect_push(K_TX, 0, 32'hEE, 1'b0);
        else
`endif
        if (!is_data) expect_push(K_TX, 0, 32'hAA, 1'b0);
        else expect_push(K_RUN, 0, 32'd0, n > 0);
        x = 8'd0;
        for (int k = 0; k < 4; k++) begin
            b = 8'(n >> (8 * k));
            x ^= b;
            send_byte(b, gmax);
        end
        for (int i = 0; i < n; i++) begin
            w = is_data ? data_q[i] : prog_q[i];
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                x ^= b;
                send_byte(b, gmax);
            end
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(bad ? (x ^ 8'h5A) : x, gmax);
`else
        if (bad) x = 8'd0;
`endif
    endtask

    task automatic run_boot(input int gmax);
        wait_tx("req_prog_tx");
        send_image(1'b0, gmax, 1'b0);
        wait_tx("req_data_tx");
        send_image(1'b1, gmax, 1'b0);
        for (int i = 0; i < 100 && !core_rstn; i++) step();
        repeat (3) step();
        chk("run_state", {28'd0, boot_state}, 32'd7);
        chk("run_core_rstn", {31'd0, core_rstn}, 32'd1);
        chk("run_sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        // Directed program/data images.
        do_reset();
        prog_q.delete();
        data_q.delete();
        prog_q.push_back(32'h00400013);
        prog_q.push_back(32'h00500093);
        data_q.push_back(32'h00000019);
        run_boot(0);

        // Zero-length program.
        do_reset();
        fill(0, 2);
        run_boot(2);

        // Reset after two body bytes: no write, back to IDLE, program re-requested.
        do_reset();
        wait_tx("midrst_req_tx");
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        step();
        reset = 1'b0;
        step();
        chk("midrst_state", {28'd0, boot_state}, 32'd0);
        chk("midrst_core_rstn", {31'd0, core_rstn}, 32'd0);
        do_reset();
        fill($urandom_range(1, 4), $urandom_range(1, 4));
        run_boot(1);

        // Randomized images with random byte gaps.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            fill($urandom_range(0, 6), $urandom_range(0, 6));
            run_boot(2);
        end

        // Over-length program wraps the instruction address.
        do_reset();
        fill(1026, 3);
        run_boot(0);

`ifdef BOOT_CHECKSUM_EN
        // Wrong checksum: 0xEE once, parked in ERR with the core held.
        do_reset();
        wait_tx("chk_req_tx");
        fill(2, 0);
        send_image(1'b0, 1, 1'b1);
        wait_tx("chk_err_tx");
        repeat (12) step();
        chk("err_state", {28'd0, boot_state}, 32'd8);
        chk("err_core_rstn", {31'd0, core_rstn}, 32'd0);
        chk("err_sb_empty", sb.size(), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

On-chip boot sequencer between the UART byte interfaces (`uart_rx`/`uart_tx`) and the pipelined core's instruction and data memories. After reset it holds the core in reset and requests a program image from the host with 0x99. It then requests a data image with 0xAA. It writes both images word by word into memory and releases the core once both phases are complete.

## Interface
Parameters:
- `IADDR_W`, 10: instruction memory word-address width.
- `DADDR_W`, 10: data memory word-address width.
- `REQ_PROG`, 8'h99: byte sent to request the program image.
- `REQ_DATA`, 8'hAA: byte sent to request the data image.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-low.
- `rx_data`  in  8: received byte from `uart_rx`.
- `rx_valid`  in  1: one-cycle pulse marking `rx_data` valid.
- `tx_busy`  in  1: `uart_tx` busy.
- `tx_data`  out  8: byte to transmit.
- `tx_start`  out  1: one-cycle transmit strobe.
- `imem_we`  out  1: instruction memory write enable.
- `imem_addr`  out  IADDR_W: instruction memory word address.
- `imem_wdata`  out  32: instruction memory write data.
- `dmem_we`  out  1: data memory write enable.
- `dmem_addr`  out  DADDR_W: data memory word address.
- `dmem_wdata`  out  32: data memory write data.
- `core_rstn`  out  1: core reset, active-low; high only in RUN.
- `boot_state`  out  4: current state encoding, for debug and LEDs.

## Operation
- Each image consists of a 4-byte word count N, little-endian, followed by N words of 4 bytes each, little-endian.
- States and transitions:
  - IDLE: go to REQ_P.
  - REQ_P: send `REQ_PROG`, then go to LEN_P.
  - LEN_P: receive 4 bytes of N, then go to BODY_P. If N==0, go directly to REQ_D.
  - BODY_P: receive N words, then go to REQ_D.
  - REQ_D: send `REQ_DATA`, then go to LEN_D.
  - LEN_D: receive 4 bytes of N, then go to BODY_D. If N==0, go directly to RUN.
  - BODY_D: receive N words, then go to RUN.
  - RUN: terminal state. Leaves only on reset.
  - ERR: exists only with the checksum feature.
- Byte assembly:
  - A 2-bit byte index selects the lane: byte k goes to bits [8k+7:8k].
  - On the 4th byte the word is complete and a write is issued.
- Addressing:
  - Word addresses start at 0 in each phase and increment after each write.
  - Addresses wrap modulo 2^ADDR_W. Over-length images overwrite from address 0; this is not an error.
- Word counter is 32-bit. A phase ends when written-word count == N.
- `rx_valid` pulses are ignored in IDLE, REQ_*, and RUN.

## Timing
- Reset values:
  - State = IDLE.
  - `tx_start`=0, `tx_data`=0.
  - `imem_we`=0, `dmem_we`=0.
  - All addresses and write data = 0.
  - `core_rstn`=0.
  - Byte index and counters = 0.
- Transmit handshake (REQ_*):
  - `tx_start` is asserted for exactly one cycle, in the first cycle the state is REQ_* and `tx_busy`==0.
  - `tx_data` holds the request byte from that cycle onward.
  - The state advances in the next cycle.
  - While `tx_busy`==1 the block waits with `tx_start`=0.
- Memory writes:
  - `*_we` is a single-cycle pulse in the cycle after the `rx_valid` that delivered byte 3.
  - Address and write data are valid in that same cycle.
  - Address increments in the following cycle.
- Phase-end transitions:
  - The last write of BODY_P is followed by REQ_D in the next cycle.
  - The last write of BODY_D is followed by RUN in the next cycle.
  - `core_rstn` rises in the first RUN cycle, 1 cycle after the final `dmem_we`.
- Back-to-back `rx_valid` on consecutive cycles must be accepted with no byte dropped.
- Reset asserted mid-phase returns the block to IDLE at the next edge. The partial word is discarded, `core_rstn` goes to 0, and the block re-requests the program image.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - Each image is followed by one XOR checksum byte covering the length and body bytes.
  - On match the block continues as normal.
  - On mismatch it enters ERR, sends 0xEE once (same handshake as REQ_*), and stays in ERR with `core_rstn`=0 until reset.
- `BOOT_CHECKSUM_EN` undefined:
  - No checksum byte is expected.
  - ERR is unreachable and its logic is absent.

## Structure
- Package `boot_pkg` holds:
  - the state enum `boot_state_t` (4-bit);
  - constants `BOOT_ERR_BYTE` = 8'hEE, `REQ_PROG_DEF` and `REQ_DATA_DEF`.
- Sub-module `word_assembler` accumulates bytes into a 32-bit little-endian word and emits a one-cycle `word_valid`. It is shared by both phases and cleared on each phase entry.

## Test plan
- Reset release:
  - Stimulus: release reset with `tx_busy`=0.
  - Response: `tx_start` pulses once with `tx_data`=0x99, and `core_rstn`=0.
- Program load:
  - Stimulus: send N=2, then bytes 13 00 40 00 / 93 00 50 00.
  - Response: `imem_we` at address 0 with 0x00400013, then at address 1 with 0x00500093. Then `tx_start` with 0xAA.
- Data load:
  - Stimulus: send N=1, then bytes 19 00 00 00.
  - Response: `dmem_we` at address 0 with 0x00000019, and `core_rstn` rises 1 cycle later.
- Zero-length program:
  - Stimulus: send N=0 for the program.
  - Response: no `imem_we`, and 0xAA is sent immediately.
- Mid-load reset:
  - Stimulus: assert reset after 2 body bytes.
  - Response: state returns to IDLE, no write is issued, and 0x99 is resent.
- Checksum error (`BOOT_CHECKSUM_EN`):
  - Stimulus: send a wrong checksum byte.
  - Response: 0xEE is sent, the block stays in ERR, and `core_rstn`=0.
